// File: rtl/md_csr_stream_bridge.sv
// md_csr_stream_bridge
//   Bridges a 64-bit host CSR window to the md_lr_top particle and force
//   streams. Particle words are assembled from CSRW-bit segment writes into
//   a staging register, then pushed into a particle FIFO that feeds the
//   pvalid/pready port with frame-aware addressing. Force results are
//   captured into a force FIFO whose head the host reads segment-wise and
//   pops explicitly.
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   csr_wr_en/addr/data CSR write strobe, index, data
//   csr_rd_addr/data    CSR read index, registered read data (1-cycle latency)
//   pvalid/pready       particle handshake; pwe mirrors pvalid
//   paddr/pdata/plast   particle address, data, end-of-frame marker
//   fvalid/fready       force handshake
//   fdata/flast         force data, end-of-frame marker
//
// CSR map
//   0        STATUS (W1C on bits 5 and 6)
//   1..NPSEG particle staging segments
//   31       PCMD  [0]=push [1]=last
//   32..     force head segments (read-only, zero when force FIFO empty)
//   63       FCMD  [0]=pop
module md_csr_stream_bridge #(
  parameter int CSRW   = 16,
  parameter int PDATAW = 125,
  parameter int FDATAW = 96,
  parameter int PADDRW = 15,
  parameter int PFIFOD = 8,
  parameter int FFIFOD = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              csr_wr_en,
  input  logic [5:0]        csr_wr_addr,
  input  logic [63:0]       csr_wr_data,
  input  logic [5:0]        csr_rd_addr,
  output logic [63:0]       csr_rd_data,
  output logic              pvalid,
  input  logic              pready,
  output logic [PADDRW-1:0] paddr,
  output logic              pwe,
  output logic [PDATAW-1:0] pdata,
  output logic              plast,
  input  logic              fvalid,
  output logic              fready,
  input  logic [FDATAW-1:0] fdata,
  input  logic              flast
);

  localparam int NPSEG = (PDATAW + CSRW - 1) / CSRW;
  localparam int NFSEG = (FDATAW + CSRW - 1) / CSRW;
  localparam int PAW   = $clog2(PFIFOD);
  localparam int PCW   = PAW + 1;
  localparam int FAW   = $clog2(FFIFOD);
  localparam int FCW   = FAW + 1;

  localparam logic [5:0] ADDR_STATUS = 6'd0;
  localparam logic [5:0] ADDR_PCMD   = 6'd31;
  localparam logic [5:0] ADDR_FCMD   = 6'd63;
  localparam logic [5:0] PSEG_END    = 6'(1 + NPSEG);
  localparam logic [5:0] FSEG_END    = 6'(32 + NFSEG);

  localparam logic [PCW-1:0] PFULL = PCW'(PFIFOD);
  localparam logic [FCW-1:0] FFULL = FCW'(FFIFOD);

  // ---------------------------------------------------------------------
  // Write decode
  // ---------------------------------------------------------------------
  logic       wr_status, wr_pcmd, wr_fcmd, wr_pseg;
  logic [4:0] pseg_idx;

  assign wr_status = csr_wr_en && (csr_wr_addr == ADDR_STATUS);
  assign wr_pcmd   = csr_wr_en && (csr_wr_addr == ADDR_PCMD);
  assign wr_fcmd   = csr_wr_en && (csr_wr_addr == ADDR_FCMD);
  assign wr_pseg   = csr_wr_en && (csr_wr_addr >= 6'd1) && (csr_wr_addr < PSEG_END);
  assign pseg_idx  = 5'(csr_wr_addr - 6'd1);

  // Only a subset of the write-data bits is meaningful for narrow CSRW.
  logic unused_wr_data;
  assign unused_wr_data = ^csr_wr_data;

  // ---------------------------------------------------------------------
  // Particle staging register: each bit belongs to exactly one segment, so
  // the top segment is naturally truncated to PDATAW.
  // ---------------------------------------------------------------------
  logic [PDATAW-1:0] staging_reg, staging_next;

  genvar gi, gb;
  generate
    for (gi = 0; gi < PDATAW; gi++) begin : g_stage_bit
      localparam logic [4:0] SEG = 5'(gi / CSRW);
      localparam int         BIT = gi % CSRW;
      assign staging_next[gi] = (wr_pseg && pseg_idx == SEG) ? csr_wr_data[BIT]
                                                             : staging_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) staging_reg <= '0;
    else       staging_reg <= staging_next;
  end

  // ---------------------------------------------------------------------
  // Particle FIFO
  // ---------------------------------------------------------------------
  logic [PDATAW:0]   pmem [PFIFOD];
  logic [PAW-1:0]    pwr_ptr_reg, prd_ptr_reg;
  logic [PCW-1:0]    pcount_reg;
  logic [15:0]       frames_reg;
  logic              pempty, pfull, push_req, push_ok, p_xfer;
  logic [PDATAW:0]   phead;

  assign pempty   = (pcount_reg == '0);
  assign pfull    = (pcount_reg == PFULL);
  assign push_req = wr_pcmd && csr_wr_data[0];
  // Fullness is judged on the registered count: a same-cycle dequeue does
  // not make room for the push.
  assign push_ok  = push_req && !pfull;
  assign p_xfer   = !pempty && pready;

  assign phead  = pmem[prd_ptr_reg];
  assign pvalid = !pempty;
  assign pwe    = pvalid;
  assign pdata  = phead[PDATAW-1:0];
  assign plast  = phead[PDATAW];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PFIFOD; i++) pmem[i] <= '0;
      pwr_ptr_reg <= '0;
      prd_ptr_reg <= '0;
      pcount_reg  <= '0;
      paddr       <= '0;
      frames_reg  <= '0;
    end else begin
      if (push_ok) begin
        pmem[pwr_ptr_reg] <= {csr_wr_data[1], staging_reg};
        pwr_ptr_reg       <= pwr_ptr_reg + PAW'(1);
      end
      if (p_xfer) begin
        prd_ptr_reg <= prd_ptr_reg + PAW'(1);
        if (plast) begin
          paddr      <= '0;
          frames_reg <= frames_reg + 16'd1;
        end else begin
          paddr      <= paddr + PADDRW'(1);
        end
      end
      if (push_ok && !p_xfer)      pcount_reg <= pcount_reg + PCW'(1);
      else if (!push_ok && p_xfer) pcount_reg <= pcount_reg - PCW'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Force FIFO. fready is registered from the next-state count so that it
  // stays low throughout reset and rises on the first edge afterwards.
  // ---------------------------------------------------------------------
  logic [FDATAW:0]   fmem [FFIFOD];
  logic [FAW-1:0]    fwr_ptr_reg, frd_ptr_reg;
  logic [FCW-1:0]    fcount_reg, fcount_next;
  logic              fready_reg, fempty, ffull, f_capture, pop_req, f_pop_ok;
  logic [FDATAW:0]   fhead;

  assign fempty    = (fcount_reg == '0);
  assign ffull     = (fcount_reg == FFULL);
  assign fready    = fready_reg;
  assign f_capture = fvalid && fready_reg;
  assign pop_req   = wr_fcmd && csr_wr_data[0];
  assign f_pop_ok  = pop_req && !fempty;
  // Stale storage is hidden so an empty FIFO reads back as zero.
  assign fhead     = fempty ? '0 : fmem[frd_ptr_reg];

  always_comb begin
    fcount_next = fcount_reg;
    if (f_capture && !f_pop_ok)      fcount_next = fcount_reg + FCW'(1);
    else if (!f_capture && f_pop_ok) fcount_next = fcount_reg - FCW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FFIFOD; i++) fmem[i] <= '0;
      fwr_ptr_reg <= '0;
      frd_ptr_reg <= '0;
      fcount_reg  <= '0;
      fready_reg  <= 1'b0;
    end else begin
      if (f_capture) begin
        fmem[fwr_ptr_reg] <= {flast, fdata};
        fwr_ptr_reg       <= fwr_ptr_reg + FAW'(1);
      end
      if (f_pop_ok) frd_ptr_reg <= frd_ptr_reg + FAW'(1);
      fcount_reg <= fcount_next;
      fready_reg <= (fcount_next != FFULL);
    end
  end

  // Force head split into zero-extended CSR segments; unused slots read 0.
  logic [63:0] fseg [32];
  generate
    for (gi = 0; gi < 32; gi++) begin : g_fseg
      for (gb = 0; gb < 64; gb++) begin : g_fbit
        if (gi < NFSEG && gb < CSRW && (gi * CSRW + gb) < FDATAW) begin : g_map
          assign fseg[gi][gb] = fhead[gi*CSRW+gb];
        end else begin : g_zero
          assign fseg[gi][gb] = 1'b0;
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Sticky flags, status and registered readback
  // ---------------------------------------------------------------------
  logic        p_ovf_reg, f_unf_reg;
  logic [8:0]  pcount_w, fcount_w;
  logic [63:0] status_word, rd_next;

  assign pcount_w = 9'(pcount_reg);
  assign fcount_w = 9'(fcount_reg);

  assign status_word = {16'd0, frames_reg, 8'd0, fcount_w[7:0], pcount_w[7:0],
                        1'b0, f_unf_reg, p_ovf_reg, fhead[FDATAW],
                        ffull, fempty, pfull, pempty};

  always_comb begin
    rd_next = '0;
    if (csr_rd_addr == ADDR_STATUS)
      rd_next = status_word;
    else if (csr_rd_addr >= 6'd32 && csr_rd_addr < FSEG_END)
      rd_next = fseg[csr_rd_addr[4:0]];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_ovf_reg   <= 1'b0;
      f_unf_reg   <= 1'b0;
      csr_rd_data <= '0;
    end else begin
      // Set and clear come from different CSR addresses, so they never
      // collide in one cycle.
      if (push_req && pfull)                    p_ovf_reg <= 1'b1;
      else if (wr_status && csr_wr_data[5])     p_ovf_reg <= 1'b0;
      if (pop_req && fempty)                    f_unf_reg <= 1'b1;
      else if (wr_status && csr_wr_data[6])     f_unf_reg <= 1'b0;
      csr_rd_data <= rd_next;
    end
  end

endmodule

// File: tb/tb_md_csr_stream_bridge.sv
// Directed testbench for md_csr_stream_bridge with scoreboard queues for
// particles (checked as they leave the pvalid/pready port) and forces
// (checked when the head is read back through the CSR window).
module tb_md_csr_stream_bridge;

  localparam int CSRW   = 16;
  localparam int PDATAW = 125;
  localparam int FDATAW = 96;
  localparam int PADDRW = 15;
  localparam int PFIFOD = 8;
  localparam int FFIFOD = 8;
  localparam int NFSEG  = (FDATAW + CSRW - 1) / CSRW;

  logic              clk = 1'b0;
  logic              reset;
  logic              csr_wr_en;
  logic [5:0]        csr_wr_addr;
  logic [63:0]       csr_wr_data;
  logic [5:0]        csr_rd_addr;
  logic [63:0]       csr_rd_data;
  logic              pvalid, pready, pwe, plast;
  logic [PADDRW-1:0] paddr;
  logic [PDATAW-1:0] pdata;
  logic              fvalid, fready, flast;
  logic [FDATAW-1:0] fdata;

  md_csr_stream_bridge #(
    .CSRW(CSRW), .PDATAW(PDATAW), .FDATAW(FDATAW),
    .PADDRW(PADDRW), .PFIFOD(PFIFOD), .FFIFOD(FFIFOD)
  ) dut (
    .clk(clk), .reset(reset),
    .csr_wr_en(csr_wr_en), .csr_wr_addr(csr_wr_addr), .csr_wr_data(csr_wr_data),
    .csr_rd_addr(csr_rd_addr), .csr_rd_data(csr_rd_data),
    .pvalid(pvalid), .pready(pready), .paddr(paddr), .pwe(pwe),
    .pdata(pdata), .plast(plast),
    .fvalid(fvalid), .fready(fready), .fdata(fdata), .flast(flast)
  );

  always #5 clk = ~clk;

  int checks_total  = 0;
  int checks_passed = 0;
  int checks_failed = 0;

  // Scoreboards and reference state
  logic [PDATAW:0]   pq [$];
  logic [FDATAW:0]   fq [$];
  logic [PDATAW-1:0] m_stage;
  logic [PADDRW-1:0] m_paddr;
  logic              m_povf, m_funf, m_fready;
  int                xfers;
  logic [PDATAW:0]   mon_exp;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else begin
      checks_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Particle monitor: a handshake seen at the falling edge completes at the
  // next rising edge.
  always @(negedge clk) begin
    if (!reset && pvalid && pready) begin
      xfers++;
      check("p_sb_nonempty", 128'(pq.size() != 0), 128'(1));
      check("pwe", 128'(pwe), 128'(1));
      if (pq.size() != 0) begin
        mon_exp = pq.pop_front();
        check("pdata", 128'(pdata), 128'(mon_exp[PDATAW-1:0]));
        check("plast", 128'(plast), 128'(mon_exp[PDATAW]));
        check("paddr", 128'(paddr), 128'(m_paddr));
        $display("particle xfer: paddr=%0d plast=%0b pdata=%0h", paddr, plast, pdata);
        if (mon_exp[PDATAW]) m_paddr = '0;
        else                 m_paddr = m_paddr + PADDRW'(1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_write(input logic [5:0] a, input logic [63:0] d);
    csr_wr_en   = 1'b1;
    csr_wr_addr = a;
    csr_wr_data = d;
    tick();
    csr_wr_en   = 1'b0;
    csr_wr_data = '0;
    $display("csr write: addr=%0d data=%0h", a, d);
  endtask

  task automatic csr_read(input logic [5:0] a, output logic [63:0] d);
    csr_rd_addr = a;
    tick();
    d = csr_rd_data;
    $display("csr read: addr=%0d data=%0h", a, d);
  endtask

  task automatic write_seg(input int i, input logic [15:0] v);
    for (int b = 0; b < CSRW; b++)
      if (i * CSRW + b < PDATAW) m_stage[i*CSRW+b] = v[b];
    csr_write(6'(1 + i), {48'd0, v});
  endtask

  // Acceptance is decided on the occupancy before the command edge.
  task automatic push(input logic last);
    if (pq.size() < PFIFOD) pq.push_back({last, m_stage});
    else                    m_povf = 1'b1;
    csr_write(6'd31, {62'd0, last, 1'b1});
  endtask

  task automatic f_cycle(input logic v, input logic [FDATAW-1:0] d, input logic l,
                         input logic pop);
    logic cap;
    logic [FDATAW:0] dummy;
    check("fready", 128'(fready), 128'(m_fready));
    fvalid      = v;
    fdata       = d;
    flast       = l;
    csr_wr_en   = pop;
    csr_wr_addr = 6'd63;
    csr_wr_data = 64'(pop);
    cap = v && m_fready;
    tick();
    if (pop) begin
      if (fq.size() != 0) dummy = fq.pop_front();
      else                m_funf = 1'b1;
    end
    if (cap) fq.push_back({l, d});
    m_fready    = (fq.size() != FFIFOD);
    fvalid      = 1'b0;
    csr_wr_en   = 1'b0;
    csr_wr_data = '0;
    $display("force cycle: fvalid=%0b cap=%0b pop=%0b depth=%0d", v, cap, pop, fq.size());
  endtask

  task automatic check_fhead(input string tag);
    logic [63:0]     r, e;
    logic [FDATAW:0] h;
    h = (fq.size() != 0) ? fq[0] : '0;
    for (int j = 0; j < NFSEG; j++) begin
      e = '0;
      for (int b = 0; b < CSRW; b++)
        if (j * CSRW + b < FDATAW) e[b] = h[j*CSRW+b];
      csr_read(6'(32 + j), r);
      check(tag, 128'(r), 128'(e));
    end
  endtask

  logic [63:0]       st, r;
  logic [FDATAW-1:0] rd;
  int                base;

  initial begin
    reset = 1'b1;
    csr_wr_en = 0; csr_wr_addr = 0; csr_wr_data = 0; csr_rd_addr = 0;
    pready = 0; fvalid = 0; fdata = 0; flast = 0;
    m_stage = '0; m_paddr = '0; m_povf = 0; m_funf = 0; m_fready = 0; xfers = 0;
    tick();
    tick();

    // Reset state
    check("rst_pvalid", 128'(pvalid), 128'(0));
    check("rst_pwe",    128'(pwe),    128'(0));
    check("rst_paddr",  128'(paddr),  128'(0));
    check("rst_pdata",  128'(pdata),  128'(0));
    check("rst_plast",  128'(plast),  128'(0));
    check("rst_fready", 128'(fready), 128'(0));
    check("rst_rd",     128'(csr_rd_data), 128'(0));
    reset = 1'b0;
    check("fready_pre_edge", 128'(fready), 128'(0));
    tick();
    check("fready_post_edge", 128'(fready), 128'(1));
    m_fready = 1'b1;

    // Segment assembly and first-push latency
    pready = 1'b1;
    for (int i = 0; i < 8; i++) write_seg(i, 16'(32'h1111 * (i + 1)));
    push(1'b0);
    check("t1_pvalid", 128'(pvalid), 128'(1));
    check("t1_paddr",  128'(paddr),  128'(0));
    check("t1_lo",     128'(pdata[15:0]),    128'(16'h1111));
    check("t1_top",    128'(pdata[124:112]), 128'(13'h0888));
    tick();
    check("t1_paddr_after", 128'(paddr), 128'(1));

    // Frame: three pushes, last one closes the frame
    write_seg(0, 16'hA5A5);
    push(1'b0);
    write_seg(1, 16'h5A5A);
    push(1'b0);
    push(1'b1);
    repeat (3) tick();
    check("t2_xfers", 128'(xfers), 128'(4));
    check("t2_paddr", 128'(paddr), 128'(0));
    csr_read(6'd0, st);
    check("t2_frames", 128'(st[47:32]), 128'(1));
    check("t2_pempty", 128'(st[0]),     128'(1));

    // Overflow with pready held low
    pready = 1'b0;
    base = xfers;
    for (int i = 0; i < 9; i++) begin
      write_seg(2, 16'(i * 3 + 7));
      push(1'b0);
    end
    csr_read(6'd0, st);
    check("t3_pcount", 128'(st[15:8]), 128'(8));
    check("t3_pfull",  128'(st[1]),    128'(1));
    check("t3_pempty", 128'(st[0]),    128'(0));
    check("t3_povf",   128'(st[5]),    128'(m_povf));
    csr_write(6'd0, 64'h20);
    m_povf = 1'b0;
    csr_read(6'd0, st);
    check("t3_povf_clr", 128'(st[5]), 128'(0));
    check("t3_pfull2",   128'(st[1]), 128'(1));
    pready = 1'b1;
    repeat (12) tick();
    check("t3_drain", 128'(xfers - base), 128'(8));
    check("t3_pvalid", 128'(pvalid), 128'(0));
    pready = 1'b0;

    // Single force capture and segment readback
    f_cycle(1'b1, 96'h0000AAAA_BBBB_CCCC_DDDD_EEEE, 1'b1, 1'b0);
    csr_read(6'd0, st);
    check("t4_fempty", 128'(st[2]),     128'(0));
    check("t4_hflast", 128'(st[4]),     128'(1));
    check("t4_fcount", 128'(st[23:16]), 128'(1));
    csr_read(6'd32, r);
    check("t4_seg0", 128'(r), 128'(16'hEEEE));
    csr_read(6'd37, r);
    check("t4_seg5", 128'(r), 128'(0));
    check_fhead("t4_head");
    f_cycle(1'b0, '0, 1'b0, 1'b1);
    csr_read(6'd0, st);
    check("t4_fempty_pop", 128'(st[2]), 128'(1));
    check_fhead("t4_head_empty");

    // Fill the force FIFO, then exercise pop under fvalid
    for (int i = 0; i < 9; i++) begin
      rd = {$urandom, $urandom, $urandom};
      f_cycle(1'b1, rd, 1'(i % 3 == 2), 1'b0);
    end
    check("t5_fready_full", 128'(fready), 128'(0));
    csr_read(6'd0, st);
    check("t5_ffull",  128'(st[3]),     128'(1));
    check("t5_fcount", 128'(st[23:16]), 128'(fq.size()));
    rd = {$urandom, $urandom, $urandom};
    f_cycle(1'b1, rd, 1'b0, 1'b1);
    rd = {$urandom, $urandom, $urandom};
    f_cycle(1'b1, rd, 1'b1, 1'b1);
    csr_read(6'd0, st);
    check("t5_fcount_simul", 128'(st[23:16]), 128'(fq.size()));
    rd = {$urandom, $urandom, $urandom};
    f_cycle(1'b1, rd, 1'b0, 1'b0);
    csr_read(6'd0, st);
    check("t5_fcount_refill", 128'(st[23:16]), 128'(8));
    for (int i = 0; i < FFIFOD; i++) begin
      csr_read(6'd0, st);
      check("t5_hflast", 128'(st[4]), 128'(fq[0][FDATAW]));
      check_fhead("t5_head");
      f_cycle(1'b0, '0, 1'b0, 1'b1);
    end
    csr_read(6'd0, st);
    check("t5_fempty", 128'(st[2]), 128'(1));
    check("t5_funf0",  128'(st[6]), 128'(0));
    f_cycle(1'b0, '0, 1'b0, 1'b1);
    csr_read(6'd0, st);
    check("t5_funf1", 128'(st[6]), 128'(m_funf));
    csr_write(6'd0, 64'h40);
    m_funf = 1'b0;
    csr_read(6'd0, st);
    check("t5_funf_clr", 128'(st[6]), 128'(0));

    // Reset in the middle of a burst
    write_seg(0, 16'h1234);
    for (int i = 0; i < 4; i++) push(1'b0);
    pready = 1'b1;
    tick();
    reset = 1'b1;
    #1;
    check("t6_pvalid", 128'(pvalid), 128'(0));
    check("t6_paddr",  128'(paddr),  128'(0));
    check("t6_pdata",  128'(pdata),  128'(0));
    check("t6_fready", 128'(fready), 128'(0));
    pq.delete();
    fq.delete();
    m_paddr = '0; m_stage = '0; m_povf = 0; m_funf = 0; m_fready = 0;
    pready = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    m_fready = 1'b1;
    csr_read(6'd0, st);
    check("t6_status", 128'(st), 128'(64'h5));
    push(1'b0);
    check("t6_fresh_valid", 128'(pvalid), 128'(1));
    check("t6_fresh_pdata", 128'(pdata),  128'(m_stage));
    base = xfers;
    pready = 1'b1;
    repeat (3) tick();
    check("t6_drain", 128'(xfers - base), 128'(1));
    pready = 1'b0;

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
